prbs_bernoulli: RTL and testbench
=================================

# prbs_bernoulli

Multi-channel, parametrised successor to the team's single-channel 32-bit PRBS source. Each channel runs an independent 32-bit LFSR and emits a Bernoulli event with a programmable probability (threshold / 2^32). Every channel also counts its events in a saturating counter. The block sits between the host configuration path (seeds, thresholds) and the per-node infection/transition logic of the disease model, which consumes `event_out` qualified by `event_valid`.

## Interface
- `NUM_CH`, 4: number of independent channels (≥1).
- `CNT_W`, 16: width of each per-channel event counter.
- `WARMUP`, 32: LFSR steps discarded after every seed load (≥1).
- `CH_W`, derived, `max(1,$clog2(NUM_CH))`: channel index width.

- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  advance all running channels by one step this cycle.
- `seed_valid`  in  1  seed load request.
- `seed_ready`  out  1  block can accept a seed this cycle.
- `seed_ch`  in  CH_W  channel to seed.
- `seed_data`  in  32  seed value.
- `thresh_we`  in  1  threshold write strobe.
- `thresh_ch`  in  CH_W  channel whose threshold is written.
- `thresh_data`  in  32  new threshold.
- `cnt_clr`  in  1  clear all event counters.
- `event_out`  out  NUM_CH  per-channel event bit, registered.
- `event_valid`  out  NUM_CH  per-channel qualifier for `event_out`, one-cycle pulse.
- `count_out`  out  NUM_CH*CNT_W  channel i counter at bits [i*CNT_W +: CNT_W].
- `ch_running`  out  NUM_CH  channel has finished warm-up.

## Operation
- LFSR step, bit 31 = MSB, per channel:
  - `fb = ~(s[31]^s[30]^s[10]^s[0])`
  - `next = {fb, s[31:1]}`
  - All-ones is the lock-up state and is never loaded.
- Event rule: event = (s < thresh), unsigned 32-bit compare on the pre-step state.
  - Threshold 0 never fires; 0xFFFFFFFF always fires.
- Global FSM, two states:
  - `RUN`:
    - `seed_ready`=1.
    - An accepted seed (`seed_valid`&&`seed_ready`) with `seed_ch`<NUM_CH loads that channel's LFSR.
    - A seed value of 0xFFFFFFFF is replaced by 0x00000000.
    - On accept, the channel's `ch_running` goes to 0, its warm-up counter loads WARMUP, and the FSM goes to `WARM`.
    - An accepted seed with `seed_ch`≥NUM_CH is consumed and ignored; the FSM stays in `RUN`.
  - `WARM`:
    - `seed_ready`=0.
    - The seeded channel steps every cycle regardless of `en` and its counter decrements.
    - After WARMUP steps, `ch_running`=1 and the FSM returns to `RUN`.
    - Other channels keep operating normally on `en`.
- Running channel with `en`=1:
  - LFSR steps.
  - `event_out[i]` is set to the compare result.
  - `event_valid[i]` pulses.
  - If the event is 1, the counter increments and saturates at 2^CNT_W−1.
- Non-running channel: `event_out[i]`=0, `event_valid[i]`=0, and its counter is held.
- Thresholds: `thresh_we` with `thresh_ch`<NUM_CH writes that channel's threshold; an out-of-range index is ignored.
- Counter priority: `rst` > `cnt_clr` > increment. `cnt_clr` coincident with an event leaves the counter at 0.

## Timing
- Reset values:
  - LFSR[i] = (i*32'h9E3779B9) mod 2^32, with 0xFFFFFFFF mapped to 0.
  - Thresholds = 0x80000000 (p=0.5).
  - Counters 0, `event_out`=0, `event_valid`=0.
  - `ch_running`=all 1s, FSM=`RUN`, `seed_ready`=1.
- Event latency: `en` high in cycle t → `event_out`/`event_valid` valid in cycle t+1, computed from the LFSR state during t.
  - `count_out` reflects that event in cycle t+1.
- A threshold write in the same cycle as `en` takes effect from the next step; the current compare uses the old value.
- Seed accept in cycle t: the LFSR holds the seed in t+1 and `ch_running[ch]`=0 from t+1.
  - `ch_running[ch]`=1 and `seed_ready`=1 again in cycle t+1+WARMUP.
  - The first `en` step for the channel can be sampled from cycle t+1+WARMUP.
- `rst` mid-warm-up aborts warm-up and restores all reset values on the next edge.
- Throughput: one step per channel per cycle, with `en` held high continuously.

## Test plan
- Reset, then step channel 0 (LFSR=0) with `en`=1 → states 0x80000000, 0x40000000, 0x20000000, 0x90000000.
  - Threshold 0x80000000 gives events 1, 0, 1, 1.
  - `count_out[0]` reaches 3.
- WARMUP=4: seed ch1 with 0 → `seed_ready` low for exactly 4 cycles, LFSR1=0x90000000 after warm-up.
  - Then `en` with threshold 0xA0000000 → event 1; with 0x80000000 → event 0.
  - `seed_valid` held during warm-up is not accepted.
- Thresholds 0 and 0xFFFFFFFF on two channels for 1000 steps → counts 0 and 1000.
  - Seed 0xFFFFFFFF → LFSR loads 0.
- CNT_W=4, threshold 0xFFFFFFFF, 20 steps → counter saturates at 15.
  - `cnt_clr` coincident with an event → counter 0.
- Threshold write concurrent with `en`; out-of-range `seed_ch`/`thresh_ch` → old threshold used for that step, no state change for out-of-range writes.
- `rst` asserted two cycles into warm-up → all outputs return to reset values next cycle, `seed_ready`=1.

Source files
------------

// File: rtl/prbs_bernoulli.sv
// Multi-channel 32-bit LFSR Bernoulli event source with programmable per-channel
// probability (threshold / 2^32), seed warm-up sequencing and saturating event counters.
module prbs_bernoulli #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned WARMUP = 32,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    seed_valid,
    output logic                    seed_ready,
    input  logic [CH_W-1:0]         seed_ch,
    input  logic [31:0]             seed_data,
    input  logic                    thresh_we,
    input  logic [CH_W-1:0]         thresh_ch,
    input  logic [31:0]             thresh_data,
    input  logic                    cnt_clr,
    output logic [NUM_CH-1:0]       event_out,
    output logic [NUM_CH-1:0]       event_valid,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic [NUM_CH-1:0]       ch_running
);

    localparam int unsigned     WU_W      = $clog2(WARMUP + 1);
    localparam logic [CH_W:0]   NUM_CH_L  = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [31:0]     THRESH_RST = 32'h8000_0000;

    typedef enum logic {RUN, WARM} state_t;

    state_t            state;
    state_t            state_next;
    logic [WU_W-1:0]   warm_cnt;
    logic [WU_W-1:0]   warm_cnt_next;
    logic [CH_W-1:0]   warm_ch;
    logic [CH_W-1:0]   warm_ch_next;
    logic              seed_load;
    logic              warm_done;

    logic [31:0]       lfsr   [NUM_CH];
    logic [31:0]       thresh [NUM_CH];
    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [NUM_CH-1:0] run_step;
    logic [NUM_CH-1:0] warm_step;
    logic [NUM_CH-1:0] hit;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {~(s[31] ^ s[30] ^ s[10] ^ s[0]), s[31:1]};
    endfunction

    // Golden-ratio spread of reset states; the all-ones lock-up value is avoided.
    function automatic logic [31:0] reset_seed(input logic [31:0] idx);
        logic [31:0] v;
        v = idx * 32'h9E37_79B9;
        return (v == 32'hFFFF_FFFF) ? 32'h0 : v;
    endfunction

    // Seed/warm-up sequencer: only one channel warms up at a time.
    always_comb begin
        state_next    = state;
        warm_cnt_next = warm_cnt;
        warm_ch_next  = warm_ch;
        seed_load     = 1'b0;
        warm_done     = 1'b0;
        if (state == RUN) begin
            if (seed_valid && ({1'b0, seed_ch} < NUM_CH_L)) begin
                seed_load     = 1'b1;
                warm_ch_next  = seed_ch;
                warm_cnt_next = WU_W'(WARMUP);
                state_next    = WARM;
            end
        end else begin
            warm_cnt_next = warm_cnt - WU_W'(1);
            if (warm_cnt == WU_W'(1)) begin
                warm_done  = 1'b1;
                state_next = RUN;
            end
        end
    end

    always_comb begin
        run_step  = '0;
        warm_step = '0;
        hit       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            run_step[i]  = ch_running[i] & en;
            warm_step[i] = (state == WARM) && (warm_ch == CH_W'(i));
            hit[i]       = lfsr[i] < thresh[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            seed_ready  <= 1'b1;
            warm_cnt    <= '0;
            warm_ch     <= '0;
            event_out   <= '0;
            event_valid <= '0;
            ch_running  <= '1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                lfsr[i]   <= reset_seed(32'(i));
                thresh[i] <= THRESH_RST;
                cnt[i]    <= '0;
            end
        end else begin
            state      <= state_next;
            seed_ready <= (state_next == RUN);
            warm_cnt   <= warm_cnt_next;
            warm_ch    <= warm_ch_next;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (seed_load && (seed_ch == CH_W'(i))) begin
                    lfsr[i]       <= (seed_data == 32'hFFFF_FFFF) ? 32'h0 : seed_data;
                    ch_running[i] <= 1'b0;
                end else begin
                    if (run_step[i] || warm_step[i]) begin
                        lfsr[i] <= lfsr_next(lfsr[i]);
                    end
                    if (warm_done && (warm_ch == CH_W'(i))) begin
                        ch_running[i] <= 1'b1;
                    end
                end
                event_valid[i] <= run_step[i];
                event_out[i]   <= run_step[i] & hit[i];
                // Clear beats increment; the counter sticks at its maximum.
                if (cnt_clr) begin
                    cnt[i] <= '0;
                end else if (run_step[i] && hit[i] && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (thresh_we && (thresh_ch == CH_W'(i))) begin
                    thresh[i] <= thresh_data;
                end
            end
        end
    end

    always_comb begin
        count_out = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            count_out[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

endmodule

// File: tb/tb_prbs_bernoulli.sv
// Bench for prbs_bernoulli: table of ch0 vectors, seed/warm-up and reset sequences,
// every cycle scored against a behavioural model through an expected-value queue.
module tb_prbs_bernoulli;

    localparam int unsigned NCH = 3;
    localparam int unsigned WU  = 4;
    localparam int unsigned CW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, en, seed_valid, thresh_we, cnt_clr;
    logic [CW-1:0]   seed_ch, thresh_ch;
    logic [31:0]     seed_data, thresh_data;
    logic            seed_ready, seed_ready_s;
    logic [NCH-1:0]  event_out, event_valid, ch_running;
    logic [NCH-1:0]  event_out_s, event_valid_s, ch_running_s;
    logic [NCH*16-1:0] count_out;
    logic [NCH*4-1:0]  count_out_s;

    prbs_bernoulli #(.NUM_CH(NCH), .CNT_W(16), .WARMUP(WU)) dut (
        .clk(clk), .rst(rst), .en(en), .seed_valid(seed_valid), .seed_ready(seed_ready),
        .seed_ch(seed_ch), .seed_data(seed_data), .thresh_we(thresh_we),
        .thresh_ch(thresh_ch), .thresh_data(thresh_data), .cnt_clr(cnt_clr),
        .event_out(event_out), .event_valid(event_valid), .count_out(count_out),
        .ch_running(ch_running)
    );

    prbs_bernoulli #(.NUM_CH(NCH), .CNT_W(4), .WARMUP(WU)) dut_s (
        .clk(clk), .rst(rst), .en(en), .seed_valid(seed_valid), .seed_ready(seed_ready_s),
        .seed_ch(seed_ch), .seed_data(seed_data), .thresh_we(thresh_we),
        .thresh_ch(thresh_ch), .thresh_data(thresh_data), .cnt_clr(cnt_clr),
        .event_out(event_out_s), .event_valid(event_valid_s), .count_out(count_out_s),
        .ch_running(ch_running_s)
    );

    typedef struct {
        logic          rst, en, sv, we, clr;
        logic [CW-1:0] sch, tch;
        logic [31:0]   sdata, tdata;
    } in_t;

    typedef struct {
        logic [NCH-1:0]    ev, val, run;
        logic              rdy;
        logic [NCH*16-1:0] cnt16;
        logic [NCH*4-1:0]  cnt4;
    } exp_t;

    typedef struct {
        logic        en, we;
        logic [1:0]  tch;
        logic [31:0] td;
        logic        clr, ev0, val0;
        int          cnt0;
    } vec_t;

    int errors = 0;
    int checks = 0;
    exp_t sbq[$];

    logic [31:0]    m_lfsr [NCH];
    logic [31:0]    m_thr  [NCH];
    int             m_cnt  [NCH];
    logic [NCH-1:0] m_run, m_ev, m_val;
    logic           m_warm;
    int             m_wch, m_wleft;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_next(input logic [31:0] s);
        logic fb;
        fb = ~(s[31] ^ s[30] ^ s[10] ^ s[0]);
        return {fb, s[31:1]};
    endfunction

    function automatic in_t idle();
        in_t s;
        s.rst = 0; s.en = 0; s.sv = 0; s.we = 0; s.clr = 0;
        s.sch = '0; s.tch = '0; s.sdata = '0; s.tdata = '0;
        return s;
    endfunction

    task automatic model_reset();
        logic [31:0] v;
        for (int i = 0; i < NCH; i++) begin
            v = 32'(i) * 32'h9E37_79B9;
            m_lfsr[i] = (v == 32'hFFFF_FFFF) ? 32'h0 : v;
            m_thr[i]  = 32'h8000_0000;
            m_cnt[i]  = 0;
        end
        m_run = '1; m_ev = '0; m_val = '0; m_warm = 0; m_wch = 0; m_wleft = 0;
    endtask

    task automatic model_step(input in_t s);
        logic run;
        if (s.rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            run      = m_run[i] && s.en;
            m_val[i] = run;
            m_ev[i]  = run && (m_lfsr[i] < m_thr[i]);
            if (s.clr) m_cnt[i] = 0;
            else if (m_ev[i]) m_cnt[i]++;
            if (run || (m_warm && m_wch == i)) m_lfsr[i] = m_next(m_lfsr[i]);
            if (s.we && int'(s.tch) == i) m_thr[i] = s.tdata;
        end
        if (m_warm) begin
            m_wleft--;
            if (m_wleft == 0) begin
                m_warm = 0;
                m_run[m_wch] = 1'b1;
            end
        end else if (s.sv && int'(s.sch) < NCH) begin
            m_wch = int'(s.sch);
            m_lfsr[m_wch] = (s.sdata == 32'hFFFF_FFFF) ? 32'h0 : s.sdata;
            m_run[m_wch] = 1'b0;
            m_warm = 1;
            m_wleft = WU;
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.ev = m_ev; e.val = m_val; e.run = m_run; e.rdy = ~m_warm;
        for (int i = 0; i < NCH; i++) begin
            e.cnt16[i*16 +: 16] = (m_cnt[i] > 65535) ? 16'hFFFF : 16'(m_cnt[i]);
            e.cnt4[i*4 +: 4]    = (m_cnt[i] > 15) ? 4'hF : 4'(m_cnt[i]);
        end
        return e;
    endfunction

    // Drive one cycle of stimulus, queue the model's prediction, score it after the edge.
    task automatic tick(input in_t s);
        exp_t e;
        @(negedge clk);
        rst = s.rst; en = s.en; seed_valid = s.sv; seed_ch = s.sch; seed_data = s.sdata;
        thresh_we = s.we; thresh_ch = s.tch; thresh_data = s.tdata; cnt_clr = s.clr;
        model_step(s);
        sbq.push_back(snap());
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("event_out", 64'(event_out), 64'(e.ev));
        chk("event_valid", 64'(event_valid), 64'(e.val));
        chk("ch_running", 64'(ch_running), 64'(e.run));
        chk("seed_ready", 64'(seed_ready), 64'(e.rdy));
        chk("count_out", 64'(count_out), 64'(e.cnt16));
        chk("count_out_sat4", 64'(count_out_s), 64'(e.cnt4));
        chk("event_out_sat4", 64'({event_out_s, ch_running_s}), 64'({e.ev, e.run}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        in_t  s;
        vec_t tbl[12];
        int   n;

        tbl[0]  = '{1, 0, 2'd0, 32'h0,         0, 1, 1, 1};
        tbl[1]  = '{1, 0, 2'd0, 32'h0,         0, 0, 1, 1};
        tbl[2]  = '{1, 0, 2'd0, 32'h0,         0, 1, 1, 2};
        tbl[3]  = '{1, 0, 2'd0, 32'h0,         0, 1, 1, 3};
        tbl[4]  = '{0, 0, 2'd0, 32'h0,         0, 0, 0, 3};
        tbl[5]  = '{1, 1, 2'd0, 32'hFFFF_FFFF, 0, 0, 1, 3};
        tbl[6]  = '{1, 1, 2'd3, 32'h0,         0, 1, 1, 4};
        tbl[7]  = '{1, 1, 2'd0, 32'h0,         0, 1, 1, 5};
        tbl[8]  = '{1, 0, 2'd0, 32'h0,         0, 0, 1, 5};
        tbl[9]  = '{1, 1, 2'd0, 32'h8000_0000, 0, 0, 1, 5};
        tbl[10] = '{1, 0, 2'd0, 32'h0,         1, 1, 1, 0};
        tbl[11] = '{1, 0, 2'd0, 32'h0,         0, 0, 1, 0};

        s = idle(); s.rst = 1;
        tick(s);
        tick(s);
        chk("reset_seed_ready", 64'(seed_ready), 64'(1));
        chk("reset_running", 64'(ch_running), 64'(3'b111));
        chk("reset_counts", 64'(count_out), 64'(0));

        // ch0 starts from LFSR 0: 0x0, 0x80000000, 0x40000000, 0x20000000, 0x90000000, ...
        foreach (tbl[k]) begin
            s = idle();
            s.en = tbl[k].en; s.we = tbl[k].we; s.tch = tbl[k].tch;
            s.tdata = tbl[k].td; s.clr = tbl[k].clr;
            tick(s);
            chk($sformatf("tbl%0d_ev0", k), 64'(event_out[0]), 64'(tbl[k].ev0));
            chk($sformatf("tbl%0d_val0", k), 64'(event_valid[0]), 64'(tbl[k].val0));
            chk($sformatf("tbl%0d_cnt0", k), 64'(count_out[15:0]), 64'(tbl[k].cnt0));
        end

        // Seed ch1 with 0; keep seed_valid high with another value during warm-up.
        s = idle(); s.sv = 1; s.sch = 2'd1; s.sdata = 32'h0;
        tick(s);
        s.sdata = 32'h1234_5678; s.en = 1;
        n = 0;
        while (seed_ready == 1'b0 && n < 20) begin
            tick(s);
            n++;
        end
        chk("warmup_cycles", 64'(n), 64'(WU));
        s = idle(); s.we = 1; s.tch = 2'd1; s.tdata = 32'hA000_0000;
        tick(s);
        s = idle(); s.en = 1;
        tick(s);
        chk("seeded_ch1_event", 64'(event_out[1]), 64'(1));

        s = idle(); s.sv = 1; s.sch = 2'd3; s.sdata = 32'h0;
        tick(s);
        chk("oob_seed_ready", 64'(seed_ready), 64'(1));
        chk("oob_seed_running", 64'(ch_running), 64'(3'b111));

        // All-ones seed must behave as a zero seed.
        s = idle(); s.sv = 1; s.sch = 2'd1; s.sdata = 32'hFFFF_FFFF;
        tick(s);
        s = idle();
        for (int k = 0; k < int'(WU); k++) tick(s);
        s = idle(); s.we = 1; s.tch = 2'd0; s.tdata = 32'h0;
        tick(s);
        s = idle(); s.we = 1; s.tch = 2'd2; s.tdata = 32'hFFFF_FFFF; s.clr = 1;
        tick(s);
        s = idle(); s.en = 1;
        for (int k = 0; k < 1000; k++) begin
            tick(s);
            if (k == 0) chk("ones_seed_ch1_event", 64'(event_out[1]), 64'(1));
        end
        chk("thresh0_count", 64'(count_out[15:0]), 64'(0));
        chk("thresh_max_count", 64'(count_out[47:32]), 64'(1000));
        chk("sat4_count", 64'(count_out_s[11:8]), 64'(15));

        // Reset two cycles into a warm-up.
        s = idle(); s.sv = 1; s.sch = 2'd2; s.sdata = 32'h0BAD_F00D;
        tick(s);
        s = idle(); s.en = 1;
        tick(s);
        tick(s);
        s = idle(); s.rst = 1;
        tick(s);
        chk("rst_warm_seed_ready", 64'(seed_ready), 64'(1));
        chk("rst_warm_running", 64'(ch_running), 64'(3'b111));
        chk("rst_warm_counts", 64'(count_out), 64'(0));
        chk("rst_warm_valid", 64'(event_valid), 64'(0));
        s = idle(); s.en = 1;
        tick(s);
        tick(s);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
